// File: rtl/ace_pkg.sv
// ace_pkg: ACE snoop codes, CR response layout, snoop FSM states and snoop decode
// Provides acsnoop_t code constants, crresp_t with bit indices, snoopState_t,
// and snoopDecode(), which maps a snoop and the line state to a response and update.
package ace_pkg;
  typedef logic [3:0] acsnoop_t;
  typedef logic [4:0] crresp_t;
  localparam acsnoop_t AcReadOnce           = 4'b0000;
  localparam acsnoop_t AcReadShared         = 4'b0001;
  localparam acsnoop_t AcReadClean          = 4'b0010;
  localparam acsnoop_t AcReadNotSharedDirty = 4'b0011;
  localparam acsnoop_t AcReadUnique         = 4'b0111;
  localparam acsnoop_t AcCleanShared        = 4'b1000;
  localparam acsnoop_t AcCleanInvalid       = 4'b1001;
  localparam acsnoop_t AcMakeInvalid        = 4'b1101;
  localparam int CrDataTransfer = 0;
  localparam int CrError        = 1;
  localparam int CrPassDirty    = 2;
  localparam int CrIsShared     = 3;
  localparam int CrWasUnique    = 4;
  typedef enum logic [2:0] {
    Idle,
    Lookup,
    Wait,
    Cr,
    Cd,
    Upd
  } snoopState_t;
  typedef struct packed {
    crresp_t resp;
    logic    invalidate;
    logic    clean;
  } snoopDec_t;
  // A miss or an unsupported snoop leaves everything zero: no data, no update.
  function automatic snoopDec_t snoopDecode(acsnoop_t snoop, logic hit, logic dirty,
                                            logic shared);
    snoopDec_t d;
    d = '0;
    if (hit) begin
      case (snoop)
        AcReadOnce: begin
          d.resp[CrDataTransfer] = 1'b1;
          d.resp[CrIsShared]     = 1'b1;
          d.resp[CrWasUnique]    = !shared;
        end
        AcReadShared, AcReadClean, AcReadNotSharedDirty: begin
          d.resp[CrDataTransfer] = 1'b1;
          d.resp[CrPassDirty]    = dirty;
          d.resp[CrIsShared]     = 1'b1;
          d.resp[CrWasUnique]    = !shared;
          d.clean                = 1'b1;
        end
        AcReadUnique: begin
          d.resp[CrDataTransfer] = 1'b1;
          d.resp[CrPassDirty]    = dirty;
          d.resp[CrWasUnique]    = !shared;
          d.invalidate           = 1'b1;
        end
        AcCleanShared: begin
          d.resp[CrDataTransfer] = dirty;
          d.resp[CrPassDirty]    = dirty;
          d.resp[CrIsShared]     = 1'b1;
          d.resp[CrWasUnique]    = !shared;
          d.clean                = dirty;
        end
        AcCleanInvalid: begin
          d.resp[CrDataTransfer] = dirty;
          d.resp[CrPassDirty]    = dirty;
          d.resp[CrWasUnique]    = !shared;
          d.invalidate           = 1'b1;
        end
        AcMakeInvalid: begin
          d.resp[CrWasUnique] = !shared;
          d.invalidate        = 1'b1;
        end
        default: d = '0;
      endcase
    end
    return d;
  endfunction
endpackage

// File: rtl/ace_snoop_responder.sv
// ace_snoop_responder: accepts one ACE snoop at a time, looks up the cache, answers on CR/CD
// Ports: clk_i/rst_ni (sync active-low); AC request in; CR response out; CD line data out
// in DataWidth beats lowest first; lookup request/grant and lookup result from the cache;
// one-cycle upd_* pulse telling the cache to clean or invalidate the snooped line.
module ace_snoop_responder
  import ace_pkg::*;
#(
  parameter int AddrWidth      = 64,
  parameter int DataWidth      = 64,
  parameter int CachelineWidth = 512
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      ac_valid_i,
  output logic                      ac_ready_o,
  input  logic [AddrWidth-1:0]      ac_addr_i,
  input  logic [3:0]                ac_snoop_i,
  output logic                      cr_valid_o,
  input  logic                      cr_ready_i,
  output logic [4:0]                cr_resp_o,
  output logic                      cd_valid_o,
  input  logic                      cd_ready_i,
  output logic [DataWidth-1:0]      cd_data_o,
  output logic                      cd_last_o,
  output logic                      lookup_req_o,
  input  logic                      lookup_gnt_i,
  output logic [AddrWidth-1:0]      lookup_addr_o,
  input  logic                      lookup_valid_i,
  input  logic                      lookup_hit_i,
  input  logic                      lookup_dirty_i,
  input  logic                      lookup_shared_i,
  input  logic [CachelineWidth-1:0] lookup_data_i,
  output logic                      upd_valid_o,
  output logic                      upd_invalidate_o,
  output logic                      upd_clean_o
);
  localparam int Beats = CachelineWidth / DataWidth;
  localparam int BeatW = $clog2(Beats);
  snoopState_t state, stateNext;
  logic [AddrWidth-1:0] addrQ;
  acsnoop_t snoopQ;
  logic [CachelineWidth-1:0] dataQ;
  crresp_t respQ;
  logic updInvQ, updCleanQ;
  logic [BeatW-1:0] beatQ;
  logic lastBeat, updDue;
  snoopDec_t dec;
  assign dec = snoopDecode(snoopQ, lookup_hit_i, lookup_dirty_i, lookup_shared_i);
  assign lastBeat = beatQ == BeatW'(Beats - 1);
  assign updDue = updInvQ | updCleanQ;
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state     <= Idle;
      addrQ     <= '0;
      snoopQ    <= '0;
      dataQ     <= '0;
      respQ     <= '0;
      updInvQ   <= 1'b0;
      updCleanQ <= 1'b0;
      beatQ     <= '0;
    end else begin
      state <= stateNext;
      if (ac_valid_i && ac_ready_o) begin
        addrQ  <= ac_addr_i;
        snoopQ <= ac_snoop_i;
      end
      if (state == Wait && lookup_valid_i) begin
        dataQ     <= lookup_data_i;
        respQ     <= dec.resp;
        updInvQ   <= dec.invalidate;
        updCleanQ <= dec.clean;
      end
      if (state == Cd && cd_ready_i) beatQ <= lastBeat ? '0 : beatQ + 1'b1;
    end
  end
  always_comb begin
    stateNext = state;
    case (state)
      Idle:    stateNext = ac_valid_i ? Lookup : Idle;
      Lookup:  stateNext = lookup_gnt_i ? Wait : Lookup;
      Wait:    stateNext = lookup_valid_i ? Cr : Wait;
      Cr:      stateNext = !cr_ready_i ? Cr : respQ[CrDataTransfer] ? Cd : updDue ? Upd : Idle;
      Cd:      stateNext = !(cd_ready_i && lastBeat) ? Cd : updDue ? Upd : Idle;
      Upd:     stateNext = Idle;
      default: stateNext = Idle;
    endcase
  end
  // ac_ready_o is gated by rst_ni so no request is accepted while reset is held.
  assign ac_ready_o       = rst_ni && state == Idle;
  assign lookup_req_o     = state == Lookup;
  assign lookup_addr_o    = addrQ;
  assign cr_valid_o       = state == Cr;
  assign cr_resp_o        = respQ;
  assign cd_valid_o       = state == Cd;
  assign cd_data_o        = dataQ[beatQ*DataWidth+:DataWidth];
  assign cd_last_o        = state == Cd && lastBeat;
  assign upd_valid_o      = state == Upd;
  assign upd_invalidate_o = state == Upd && updInvQ;
  assign upd_clean_o      = state == Upd && updCleanQ;
endmodule

// File: tb/tb_ace_snoop_responder.sv
// tb_ace_snoop_responder: directed snoop transactions checked against a spec-level model
module tb_ace_snoop_responder;
  localparam int AW = 64, DW = 64, CW = 512, NB = CW / DW;
  logic clk = 0, rst_n = 0;
  always #5 clk = ~clk;
  logic ac_valid = 0, cr_ready = 0, cd_ready = 0, lookup_gnt = 0, lookup_valid = 0;
  logic lookup_hit = 0, lookup_dirty = 0, lookup_shared = 0;
  logic [AW-1:0] ac_addr = '0;
  logic [3:0] ac_snoop = '0;
  logic [CW-1:0] lookup_data = '0;
  logic ac_ready_o, cr_valid_o, cd_valid_o, cd_last_o, lookup_req_o;
  logic upd_valid_o, upd_invalidate_o, upd_clean_o;
  logic [4:0] cr_resp_o;
  logic [DW-1:0] cd_data_o;
  logic [AW-1:0] lookup_addr_o;
  ace_snoop_responder #(.AddrWidth(AW), .DataWidth(DW), .CachelineWidth(CW)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .ac_valid_i(ac_valid), .ac_ready_o(ac_ready_o), .ac_addr_i(ac_addr), .ac_snoop_i(ac_snoop),
    .cr_valid_o(cr_valid_o), .cr_ready_i(cr_ready), .cr_resp_o(cr_resp_o),
    .cd_valid_o(cd_valid_o), .cd_ready_i(cd_ready), .cd_data_o(cd_data_o), .cd_last_o(cd_last_o),
    .lookup_req_o(lookup_req_o), .lookup_gnt_i(lookup_gnt), .lookup_addr_o(lookup_addr_o),
    .lookup_valid_i(lookup_valid), .lookup_hit_i(lookup_hit), .lookup_dirty_i(lookup_dirty),
    .lookup_shared_i(lookup_shared), .lookup_data_i(lookup_data),
    .upd_valid_o(upd_valid_o), .upd_invalidate_o(upd_invalidate_o), .upd_clean_o(upd_clean_o)
  );
  int total = 0, bad = 0;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask
  function automatic logic [4:0] modelResp(input logic [3:0] s, input logic hit, input logic dirty,
                                           input logic shared);
    bit isRead, isClean, known;
    logic dt, pd, is;
    isRead  = s inside {4'd0, 4'd1, 4'd2, 4'd3, 4'd7};
    isClean = s inside {4'd8, 4'd9};
    known   = isRead || isClean || s == 4'd13;
    if (!hit || !known) return 5'd0;
    dt = isRead ? 1'b1 : isClean ? dirty : 1'b0;
    pd = (s == 4'd0 || s == 4'd13) ? 1'b0 : dirty;
    is = s inside {4'd0, 4'd1, 4'd2, 4'd3, 4'd8};
    return {!shared, is, pd, 1'b0, dt};
  endfunction
  function automatic logic [1:0] modelUpd(input logic [3:0] s, input logic hit, input logic dirty);
    if (!hit) return 2'b00;
    return {s inside {4'd7, 4'd9, 4'd13}, s inside {4'd1, 4'd2, 4'd3} || (s == 4'd8 && dirty)};
  endfunction
  logic mon = 0, expInv = 0, expClean = 0, prevStall = 0;
  logic [4:0] expResp = 0, gotResp = 0;
  logic [CW-1:0] expData = '0;
  logic [AW-1:0] expAddr = '0;
  logic [DW-1:0] prevData = '0;
  int crHs = 0, cdHs = 0, updCnt = 0, gntHs = 0;
  always @(negedge clk) begin
    if (mon && rst_n) begin
      chk("cr_cd_overlap", 64'(cr_valid_o & cd_valid_o), 0);
      if (ac_ready_o) chk("ready_while_busy", 64'(cr_valid_o | cd_valid_o | upd_valid_o | lookup_req_o), 0);
      if (lookup_req_o) begin
        chk("lookup_addr", lookup_addr_o, expAddr);
        if (lookup_gnt) gntHs++;
      end
      if (cr_valid_o) begin
        chk("cr_resp", 64'(cr_resp_o), 64'(expResp));
        if (cr_ready) begin
          crHs++;
          gotResp = cr_resp_o;
        end
      end
      if (cd_valid_o) begin
        chk("cd_data", cd_data_o, expData[cdHs*DW+:DW]);
        chk("cd_last", 64'(cd_last_o), 64'(cdHs == NB - 1));
        if (prevStall) chk("cd_hold", cd_data_o, prevData);
        if (cd_ready) cdHs++;
      end
      prevStall = cd_valid_o && !cd_ready;
      prevData  = cd_data_o;
      if (upd_valid_o) begin
        updCnt++;
        chk("upd_inv", 64'(upd_invalidate_o), 64'(expInv));
        chk("upd_clean", 64'(upd_clean_o), 64'(expClean));
      end
    end
  end
  function automatic logic [CW-1:0] mkLine(input logic [31:0] seed);
    logic [CW-1:0] l;
    for (int k = 0; k < NB; k++) l[k*DW+:DW] = {seed, 32'(k) ^ 32'h0f0f_0000};
    return l;
  endfunction
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic runTxn(input string nm, input logic [3:0] sn, input logic [AW-1:0] a,
                        input logic hit, input logic dirty, input logic shared,
                        input logic [31:0] seed, input int gntDly, input int crDly,
                        input bit toggle, input int rstBeat, input logic [4:0] litResp);
    logic [1:0] u;
    bit dt;
    int n;
    expResp = modelResp(sn, hit, dirty, shared);
    u = modelUpd(sn, hit, dirty);
    {expInv, expClean} = u;
    dt = expResp[0];
    expData = mkLine(seed);
    expAddr = a;
    crHs = 0; cdHs = 0; updCnt = 0; gntHs = 0; prevStall = 0; gotResp = 0;
    mon = 1;
    ac_valid = 1; ac_addr = a; ac_snoop = sn;
    n = 0;
    while (!ac_ready_o && n < 50) begin tick(); n++; end
    tick();
    ac_valid = 0; ac_addr = '1; ac_snoop = 4'hf;
    repeat (gntDly) tick();
    lookup_gnt = 1;
    tick();
    lookup_gnt = 0;
    lookup_valid = 1; lookup_hit = hit; lookup_dirty = dirty; lookup_shared = shared;
    lookup_data = expData;
    tick();
    lookup_valid = 0; lookup_hit = 0; lookup_dirty = 0; lookup_shared = 0; lookup_data = '1;
    repeat (crDly) tick();
    cr_ready = 1;
    n = 0;
    while (crHs == 0 && n < 50) begin tick(); n++; end
    cr_ready = 0;
    chk({nm, "_resp_lit"}, 64'(gotResp), 64'(litResp));
    if (!dt && u == 2'b00) chk({nm, "_ready_next"}, 64'(ac_ready_o), 1);
    if (dt) begin
      n = 0;
      while (cdHs < NB && n < 100) begin
        if (rstBeat >= 0 && cdHs == rstBeat) break;
        cd_ready = toggle ? (n % 2 == 0) : 1'b1;
        tick();
        n++;
      end
      cd_ready = 0;
    end
    if (rstBeat >= 0) begin
      rst_n = 0;
      tick();
      chk({nm, "_rst_valids"}, 64'({cr_valid_o, cd_valid_o, upd_valid_o, lookup_req_o, ac_ready_o}), 0);
      chk({nm, "_rst_data"}, cd_data_o, 0);
      rst_n = 1;
      repeat (6) tick();
      chk({nm, "_rst_no_upd"}, 64'(updCnt), 0);
      chk({nm, "_rst_beats"}, 64'(cdHs), 64'(rstBeat));
      chk({nm, "_rst_idle"}, 64'(ac_ready_o), 1);
    end else begin
      n = 0;
      while (!ac_ready_o && n < 20) begin tick(); n++; end
      chk({nm, "_idle"}, 64'(ac_ready_o), 1);
      chk({nm, "_cr_hs"}, 64'(crHs), 1);
      chk({nm, "_gnt_hs"}, 64'(gntHs), 1);
      chk({nm, "_cd_beats"}, 64'(cdHs), dt ? 64'(NB) : 0);
      chk({nm, "_upd_cnt"}, 64'(updCnt), 64'(u != 2'b00));
    end
    mon = 0;
  endtask
  initial begin
    repeat (3) tick();
    chk("reset_outputs", 64'({ac_ready_o, cr_valid_o, cd_valid_o, upd_valid_o, lookup_req_o}), 0);
    chk("reset_cd_data", cd_data_o, 0);
    rst_n = 1;
    tick();
    chk("reset_release_ready", 64'(ac_ready_o), 1);
    runTxn("rdshared", 4'b0001, 64'h1000, 1, 1, 0, 32'hA000_0001, 0, 0, 0, -1, 5'b11101);
    runTxn("rdunique", 4'b0111, 64'h2040, 1, 0, 1, 32'hB000_0002, 0, 0, 1, -1, 5'b00001);
    runTxn("rdonce_miss", 4'b0000, 64'h3000, 0, 1, 0, 32'hC000_0003, 0, 0, 0, -1, 5'b00000);
    runTxn("clnshared_clean", 4'b1000, 64'h4000, 1, 0, 1, 32'hD000_0004, 0, 0, 0, -1, 5'b01000);
    runTxn("clninvalid_dirty", 4'b1001, 64'h5000, 1, 1, 1, 32'hE000_0005, 0, 0, 0, -1, 5'b00101);
    runTxn("rdonce_delays", 4'b0000, 64'h6080, 1, 0, 0, 32'hF000_0006, 5, 4, 0, -1, 5'b11001);
    runTxn("mkinvalid", 4'b1101, 64'h7000, 1, 1, 0, 32'h1000_0007, 0, 0, 0, -1, 5'b10000);
    runTxn("unsupported", 4'b0101, 64'h8000, 1, 1, 0, 32'h2000_0008, 0, 0, 0, -1, 5'b00000);
    runTxn("clnshared_dirty", 4'b1000, 64'h9000, 1, 1, 0, 32'h3000_0009, 1, 2, 1, -1, 5'b11101);
    runTxn("rdclean_reset", 4'b0010, 64'hA000, 1, 1, 1, 32'h4000_000A, 0, 0, 0, 3, 5'b01101);
    runTxn("rdnsd_after_rst", 4'b0011, 64'hB000, 1, 0, 0, 32'h5000_000B, 0, 1, 1, -1, 5'b11001);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
